// File: rtl/m_user_input_encoder_pkg.sv
// Shared user-input command codes, button bit positions,
// repeat-timer state type and the command priority encoder.
package m_user_input_encoder_pkg;

    localparam int USER_INPUT_WIDTH = 4;

    typedef logic [USER_INPUT_WIDTH-1:0] user_input_t;

    localparam user_input_t USER_INPUT_INC  = 4'b1000;
    localparam user_input_t USER_INPUT_DEC  = 4'b0100;
    localparam user_input_t USER_INPUT_AUX  = 4'b0010;
    localparam user_input_t USER_INPUT_PILE = 4'b0001;

    localparam int IDX_PILE = 0;
    localparam int IDX_AUX  = 1;
    localparam int IDX_DEC  = 2;
    localparam int IDX_INC  = 3;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_PERIOD
    } rep_state_e;

    // Pick one command out of the same-cycle events;
    // everything that loses is dropped.
    function automatic user_input_t encode_events(
        input user_input_t ev
    );
        user_input_t code;
        code = '0;
        priority case (1'b1)
            ev[IDX_PILE]: code = USER_INPUT_PILE;
            ev[IDX_INC]:  code = USER_INPUT_INC;
            ev[IDX_DEC]:  code = USER_INPUT_DEC;
            ev[IDX_AUX]:  code = USER_INPUT_AUX;
            default:      code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/m_user_input_encoder_if.sv
// Board-side bundle of the user-input encoder: raw buttons in,
// one-hot command pulse and debounced levels out.
interface m_user_input_encoder_if;
    import m_user_input_encoder_pkg::*;

    user_input_t i_btn;
    user_input_t o_user_input;
    user_input_t o_btn_level;

    modport master (
        output i_btn,
        input  o_user_input,
        input  o_btn_level
    );

    modport slave (
        input  i_btn,
        output o_user_input,
        output o_btn_level
    );

endinterface

// File: rtl/m_button_debouncer.sv
// One push-button: 2-FF synchroniser, counting debouncer and
// registered rising-edge (press) detector.
module m_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             press_q;

    // bring the asynchronous pin into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // accept a new level only after it differs for the full window
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync_b == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_b;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // delayed level and one-cycle press flag on a 0->1 of stable
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            level_q <= stable;
            press_q <= stable & ~level_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/m_user_input_encoder.sv
// Four debounced buttons -> one-hot single-cycle command pulses.
// Macro AUTO_REPEAT_EN adds hold-to-repeat for INC and DEC.
module m_user_input_encoder
    import m_user_input_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input logic                   w_clk,
    input logic                   w_rst,
    m_user_input_encoder_if.slave bus
);
    user_input_t press;
    user_input_t level;
    user_input_t rep_fire;
    user_input_t req;
    user_input_t code_q;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 ||
        REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("m_user_input_encoder: bad timing parameters");
    end

    for (genvar g = 0; g < USER_INPUT_WIDTH; g++) begin : g_btn
        m_button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (w_clk),
            .rst   (w_rst),
            .btn   (bus.i_btn[g]),
            .level (level[g]),
            .press (press[g])
        );
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD);

    logic [1:0] rep_hit;

    for (genvar g = 0; g < 2; g++) begin : g_rep
        localparam int B = IDX_DEC + g;

        rep_state_e       state;
        rep_state_e       state_n;
        logic [REP_W-1:0] cnt;
        logic [REP_W-1:0] cnt_n;
        logic [REP_W-1:0] limit;
        logic             hit;

        // repeat timer state and counter registers
        always_ff @(posedge w_clk) begin
            if (w_rst) begin
                state <= REP_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
            end
        end

        // arm on press, fire at the limit, disarm on release
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            hit     = 1'b0;
            limit   = (state == REP_DELAY) ? REP_FIRST : REP_NEXT;
            unique case (state)
                REP_IDLE: begin
                    if (press[B]) begin
                        state_n = REP_DELAY;
                        cnt_n   = REP_W'(1);
                    end
                end
                REP_DELAY, REP_PERIOD: begin
                    if (!level[B]) begin
                        state_n = REP_IDLE;
                        cnt_n   = '0;
                    end else if (press[B]) begin
                        state_n = REP_DELAY;
                        cnt_n   = REP_W'(1);
                    end else if (cnt == limit) begin
                        hit     = 1'b1;
                        state_n = REP_PERIOD;
                        cnt_n   = REP_W'(1);
                    end else begin
                        cnt_n = cnt + REP_W'(1);
                    end
                end
                default: begin
                    state_n = REP_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        assign rep_hit[g] = hit;
    end

    assign rep_fire = {rep_hit, 2'b00};
`else
    assign rep_fire = '0;
`endif

    assign req = press | rep_fire;

    // one-hot command register, one cycle per accepted event
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            code_q <= '0;
        end else begin
            code_q <= encode_events(req);
        end
    end

    assign bus.o_user_input = code_q;
    assign bus.o_btn_level  = level;

endmodule

// File: tb/tb_m_user_input_encoder.sv
// Bench for m_user_input_encoder: directed and random button
// activity against a sample-window reference with a pulse scoreboard.
`timescale 1ns/1ps
module tb_m_user_input_encoder;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 8;
    localparam int NCYC = 8192;

    typedef struct packed {
        int         cyc;
        logic [3:0] code;
    } exp_t;

    logic w_clk;
    logic w_rst;
    logic stop_req;
    int   cyc;
    int   checks;
    int   fails;

    logic [3:0] hist    [NCYC];
    logic [3:0] lvl_exp [NCYC];
    bit         rst_at  [NCYC];
    exp_t       q[$];

    m_user_input_encoder_if bus();

    m_user_input_encoder #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (bus)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    function automatic logic [3:0] prio(input logic [3:0] ev);
        if (ev[0]) return 4'b0001;
        if (ev[3]) return 4'b1000;
        if (ev[2]) return 4'b0100;
        if (ev[1]) return 4'b0010;
        return 4'b0000;
    endfunction

    // Reference: a button's accepted level changes once its raw
    // samples have all shown the other value for DEB consecutive
    // cycles (seen two cycles late); a press shows two cycles later.
    initial begin : model
        logic [3:0] stable;
        logic [3:0] ev;
        logic       v;
        bit         win;
        int         n;
        exp_t       e;
`ifdef AUTO_REPEAT_EN
        int         rep_next [4];
        bit         rep_on   [4];
        for (int b = 0; b < 4; b++) begin
            rep_next[b] = 0;
            rep_on[b]   = 1'b0;
        end
`endif
        stable = '0;
        cyc    = 0;
        for (int i = 0; i < NCYC; i++) begin
            hist[i]    = '0;
            lvl_exp[i] = '0;
            rst_at[i]  = 1'b0;
        end
        forever begin
            @(posedge w_clk);
            cyc = cyc + 1;
            n   = cyc;
            if (w_rst) begin
                rst_at[n]    = 1'b1;
                hist[n]      = '0;
                hist[n-1]    = '0;
                stable       = '0;
                lvl_exp[n]   = '0;
                lvl_exp[n+1] = '0;
`ifdef AUTO_REPEAT_EN
                for (int b = 0; b < 4; b++) rep_on[b] = 1'b0;
`endif
            end else begin
                hist[n] = bus.i_btn;
                ev      = '0;
                for (int b = 0; b < 4; b++) begin
                    v   = ~stable[b];
                    win = (n >= DEB + 1);
                    for (int k = n - 1 - DEB; k <= n - 2; k++) begin
                        if (k >= 0 && hist[k][b] != v) win = 1'b0;
                    end
                    if (win) begin
                        stable[b] = v;
                        if (v) ev[b] = 1'b1;
`ifdef AUTO_REPEAT_EN
                        rep_on[b]   = v;
                        rep_next[b] = n + 2 + RDLY;
`endif
                    end
                end
`ifdef AUTO_REPEAT_EN
                for (int b = 2; b < 4; b++) begin
                    if (rep_on[b] && !ev[b] && rep_next[b] == n + 2) begin
                        ev[b]       = 1'b1;
                        rep_next[b] = rep_next[b] + RPER;
                    end
                end
`endif
                lvl_exp[n+1] = stable;
                if (ev != 4'b0000) begin
                    e.cyc  = n + 2;
                    e.code = prio(ev);
                    q.push_back(e);
                end
            end
        end
    end

    // Scoreboard: levels every cycle, pulses whenever one appears.
    initial begin : monitor
        exp_t e;
        int   n;
        checks = 0;
        fails  = 0;
        forever begin
            @(negedge w_clk);
            n = cyc;
            while (q.size() > 0 && q[0].cyc <= n &&
                   (rst_at[q[0].cyc] || rst_at[q[0].cyc-1])) begin
                e = q.pop_front();
            end
            if (n >= 2) begin
                checks++;
                if (bus.o_btn_level !== lvl_exp[n]) begin
                    fails++;
                    $display("FAIL btn_level cyc=%0d got=%b want=%b",
                             n, bus.o_btn_level, lvl_exp[n]);
                end
                while (q.size() > 0 && q[0].cyc < n) begin
                    e = q.pop_front();
                    checks++;
                    fails++;
                    $display("FAIL missed_pulse cyc=%0d got=0000 want=%b",
                             e.cyc, e.code);
                end
                if (bus.o_user_input !== 4'b0000) begin
                    checks++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_pulse cyc=%0d got=%b want=0000",
                                 n, bus.o_user_input);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != n || e.code !== bus.o_user_input) begin
                            fails++;
                            $display("FAIL pulse cyc=%0d got=%b want=%b@%0d",
                                     n, bus.o_user_input, e.code, e.cyc);
                        end
                    end
                end
            end
            if (stop_req) begin
                checks++;
                if (q.size() != 0) begin
                    fails++;
                    $display("FAIL pending got=%0d want=0", q.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures",
                         checks, fails);
                $finish;
            end
        end
    end

    task automatic drive(input logic [3:0] v, input int n,
                         input logic r);
        for (int i = 0; i < n; i++) begin
            @(posedge w_clk);
            #1;
            bus.i_btn = v;
            w_rst     = r;
        end
    endtask

    initial begin : stim
        logic [3:0] v;
        int         len;
        stop_req  = 1'b0;
        w_rst     = 1'b1;
        bus.i_btn = '0;
        drive(4'b0000, 3, 1'b1);
        drive(4'b0000, 5, 1'b0);
        drive(4'b1000, 20, 1'b0);
        drive(4'b0000, 20, 1'b0);
        drive(4'b0001, 3, 1'b0);
        drive(4'b0000, 15, 1'b0);
        drive(4'b1001, 30, 1'b0);
        drive(4'b0000, 20, 1'b0);
        drive(4'b1000, 10, 1'b0);
        drive(4'b0000, 10, 1'b0);
        drive(4'b1000, 10, 1'b0);
        drive(4'b0000, 20, 1'b0);
        drive(4'b1000, 5, 1'b0);
        drive(4'b1000, 1, 1'b1);
        drive(4'b1000, 15, 1'b0);
        drive(4'b0000, 20, 1'b0);
        drive(4'b0100, 60, 1'b0);
        drive(4'b0000, 30, 1'b0);
        drive(4'b1000, 20, 1'b0);
        drive(4'b0000, 3, 1'b0);
        drive(4'b1000, 10, 1'b0);
        drive(4'b0000, 20, 1'b0);
        drive(4'b0110, DEB, 1'b0);
        drive(4'b0000, 20, 1'b0);
        for (int s = 0; s < 350; s++) begin
            v   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) drive(v, 1, 1'b1);
            drive(v, len, 1'b0);
        end
        drive(4'b0000, 40, 1'b0);
        stop_req = 1'b1;
        drive(4'b0000, 5, 1'b0);
        $display("FAIL stop_timeout got=running want=finished");
        $fatal(1, "bench did not stop");
    end

endmodule
